// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed 7-segment scan driver with frame-synchronous display update,
// leading-zero suppression and a one-cycle anode ghost guard per digit slot.
// Outputs (seg_n, dp_n, an_n) are registered one cycle behind the digit index.
// Optional feature: define SEG_SCAN_BLINK_EN to enable per-digit blinking
// driven by a frame counter; without it blink_mask is ignored.
module seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);

    localparam int         PW        = $clog2(CLK_DIV);
    localparam int         IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit6..bit0 = g,f,e,d,c,b,a
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic                frame_tick_q;
    logic                slot_end;
    logic                frame_wrap;

    logic [4*DIGITS-1:0] pend_val_q;
    logic [DIGITS-1:0]   pend_dp_q;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;

    logic [DIGITS-1:0]   blink_now;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   an_d;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;

    logic [6:0]          seg_q;
    logic                dp_q;
    logic [DIGITS-1:0]   an_q;

    assign slot_end   = (presc_q == PW'(CLK_DIV - 1));
    assign frame_wrap = slot_end && (idx_q == IW'(DIGITS - 1));

    // Prescaler, digit index and frame_tick (high in the first cycle of idx=0 after a wrap)
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_wrap;
            if (slot_end) begin
                presc_q <= '0;
                idx_q   <= frame_wrap ? '0 : idx_q + IW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Next display contents: only changes in the frame_tick cycle; a load in
    // that same cycle bypasses the pending register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (frame_tick_q) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
            end else begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end
    end

    // Pending and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
        end else begin
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frame_cnt_q;
    logic          blink_phase_q;

    // Frame counter: blink phase toggles after every BLINK_FRAMES completed frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + FW'(1);
            end
        end
    end

    assign blink_now = blink_phase_q ? blink_mask : '0;
`else
    logic unused_blink;

    assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
    assign blink_now    = '0;
`endif

    // Digit select and blanking for the current index, decoded from the
    // next-state display so a frame-boundary update shows from digit 0.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        an_d       = '1;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above & (disp_val_d[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                an_d[i]   = 1'b0;
                cur_nib   = disp_val_d[4*i +: 4];
                cur_dp    = disp_dp_d[i];
                cur_blank = (blank_lz & lz_blank[i]) | blink_now[i];
            end
        end
    end

    // Registered outputs; the cycle after each index change is an all-off guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else if (slot_end) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= cur_blank ? SEG_BLANK : glyph(cur_nib);
            dp_q  <= cur_blank | ~cur_dp;
            an_q  <= an_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign an_n       = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
// Directed stimulus for seg_scan_driver (DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2).
// Stimulus pushes the expected digit presentations into a queue; a monitor
// pops one entry each time a digit is first driven after a guard cycle.
// Define SEG_SCAN_BLINK_EN here as well when building the blink variant.
module tb_seg_scan_driver;

    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        load       = 1'b0;
    logic [15:0] value      = 16'h0;
    logic [3:0]  dp_in      = 4'h0;
    logic        blank_lz   = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .CLK_DIV     (CLK_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp);
        exp_q.push_back(obs_t'({an, seg, dp}));
    endtask

    // One frame of expectations, digit 0 first; dpn holds dp_n per digit
    task automatic push4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] dpn);
        push(4'hE, s0, dpn[0]);
        push(4'hD, s1, dpn[1]);
        push(4'hB, s2, dpn[2]);
        push(4'h7, s3, dpn[3]);
    endtask

    // Monitor: a digit is presented when an_n leaves the all-off guard state
    logic [3:0] an_prev = 4'hF;
    always @(negedge clk) begin
        if (rst_n && an_prev == 4'hF && an_n != 4'hF && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("scan_an%h", an_n), 16'({an_n, seg_n, dp_n}), 16'(mon_e));
        end
        an_prev = an_n;
    end

`ifdef SEG_SCAN_BLINK_EN
    int ticks;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ticks <= 0;
        else if (frame_tick) ticks <= ticks + 1;
    end
`endif

    task automatic wait_tick();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_tick) return;
        end
        check("tick_timeout", 16'(frame_tick), 16'h1);
    endtask

    task automatic wait_an(input logic [3:0] want);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an_n == want) return;
        end
        check("an_timeout", 16'(an_n), 16'(want));
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 16'(exp_q.size()), 16'h0);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        @(negedge clk);
        value = v;
        dp_in = dp;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic vis;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_seg", 16'(seg_n), 16'h7F);
        check("rst_an", 16'(an_n), 16'hF);
        check("rst_dp", 16'(dp_n), 16'h1);
        check("rst_tick", 16'(frame_tick), 16'h0);
        rst_n = 1'b1;

        // Mid-slot reset takes effect without a clock edge
        wait_an(4'hD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seg", 16'(seg_n), 16'h7F);
        check("mid_rst_an", 16'(an_n), 16'hF);
        check("mid_rst_dp", 16'(dp_n), 16'h1);
        check("mid_rst_tick", 16'(frame_tick), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First slot_end in the 4th cycle after release: guard shows after it
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("release_an%0d", k), 16'(an_n), (k == 3) ? 16'hF : 16'hE);
        end

        // Scan and decode
        load_val(16'h1A3F, 4'b0100);
        wait_tick();
        push4(7'h0E, 7'h30, 7'h08, 7'h79, 4'b1011);
        @(negedge clk);
        check("tick_width", 16'(frame_tick), 16'h0);
        drain();

        // Tearing: load during digit 2, old glyphs until the frame boundary
        wait_an(4'hB);
        value = 16'h1111;
        dp_in = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("tear_seg", 16'(seg_n), 16'h08);
        check("tear_dp", 16'(dp_n), 16'h0);
        push(4'h7, 7'h79, 1'b1);
        wait_tick();
        push4(7'h79, 7'h79, 7'h79, 7'h79, 4'b1111);
        drain();

        // Load coincident with frame_tick applies to that frame
        wait_tick();
        value = 16'h2222;
        load  = 1'b1;
        push4(7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);
        @(negedge clk);
        load  = 1'b0;
        drain();
        wait_tick();
        push4(7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);
        drain();

        // Leading-zero suppression
        blank_lz = 1'b1;
        load_val(16'h0000, 4'b1111);
        wait_tick();
        push4(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1110);
        drain();
        load_val(16'h0050, 4'b0000);
        wait_tick();
        push4(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b1111);
        drain();
        load_val(16'h1000, 4'b0000);
        wait_tick();
        push4(7'h40, 7'h40, 7'h40, 7'h79, 4'b1111);
        drain();
        blank_lz = 1'b0;

        // Blink on digit 0
        blink_mask = 4'b0001;
        load_val(16'h5555, 4'b0000);
        for (int f = 0; f < 6; f++) begin
            wait_tick();
`ifdef SEG_SCAN_BLINK_EN
            vis = ((((ticks + 1) / BLINK_FRAMES) % 2) == 0);
`else
            vis = 1'b1;
`endif
            push4(vis ? 7'h12 : 7'h7F, 7'h12, 7'h12, 7'h12, 4'b1111);
            drain();
        end

        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, meaning clocks per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink half-period (>=1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports listed in REQ-005 to REQ-014.
REQ-005 SHALL have port clk, input, 1 bit: the sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port load, input, 1 bit: single-cycle strobe that captures value and dp_in.
REQ-008 SHALL have port value, input, 4*DIGITS bits: hex nibbles, where nibble i is digit i and digit 0 is least significant.
REQ-009 SHALL have port dp_in, input, DIGITS bits: decimal point request per digit.
REQ-010 SHALL have port blank_lz, input, 1 bit: enables leading-zero suppression.
REQ-011 SHALL have port blink_mask, input, DIGITS bits: per-digit blink enable.
REQ-012 SHALL have port seg_n, output, 7 bits: active-low segments, bit6..bit0 = g,f,e,d,c,b,a.
REQ-013 SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-014 SHALL have ports an_n, output, DIGITS bits (active-low digit enables, one-hot), and frame_tick, output, 1 bit (one-cycle pulse at frame start).

Function
REQ-015 SHALL run a prescaler 0..CLK_DIV-1 that wraps and asserts slot_end at CLK_DIV-1.
REQ-016 SHALL advance the digit index idx on slot_end, counting 0..DIGITS-1 and wrapping to 0; the wrap defines a frame boundary.
REQ-017 SHALL pulse frame_tick high for exactly the cycle in which idx becomes 0 after a wrap.
REQ-018 SHALL, on load, capture value and dp_in into a pending register.
REQ-019 SHALL copy pending to the display register only at a frame boundary, so there is no mid-frame tearing.
REQ-020 SHALL, when load coincides with a frame boundary, write value and dp_in directly to the display register.
REQ-021 SHALL register seg_n, dp_n and an_n, so outputs reflect idx with one cycle of latency.
REQ-022 SHALL drive an_n all-ones for one cycle after each idx change (ghost guard), then assert bit idx low.
REQ-023 SHALL use glyphs 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); a blank digit is 7F.
REQ-024 SHALL, when blank_lz=1, blank each zero nibble above the most significant nonzero nibble; digit 0 is never blanked.
REQ-025 SHALL give a blanked digit seg_n=7F and dp_n=1, while an_n still scans normally.
REQ-026 SHALL drive dp_n = ~display_dp[idx] for unblanked digits.

Reset
REQ-027 SHALL, while rst_n=0, immediately force prescaler=0, idx=0, pending=0, display=0, blink phase=0, seg_n=7F, dp_n=1, an_n=all-ones and frame_tick=0, including mid-frame.
REQ-028 SHALL resume with the first slot_end CLK_DIV cycles after rst_n deasserts.

Configuration
REQ-029 SHALL, with SEG_SCAN_BLINK_EN defined, count frames and toggle blink phase every BLINK_FRAMES frames; in phase 1, masked digits are blanked per REQ-025.
REQ-030 SHALL, without SEG_SCAN_BLINK_EN, omit the frame counter and phase, ignore blink_mask, and never blink.

Verification (DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2)
REQ-031 SHALL cover reset: rst_n=0 mid-slot -> seg_n=7F, an_n=F, dp_n=1 the same cycle; first slot_end 4 cycles after release.
REQ-032 SHALL cover scan and decode: load value=16'h1A3F, blank_lz=0 -> after the next frame boundary, the digit sequence is F(0E), 3(30), A(08), 1(79), with an_n=E,D,B,7, each preceded by one an_n=F guard cycle.
REQ-033 SHALL cover tearing: load 16'h1111 at idx=2 -> digits 2 and 3 keep old glyphs until frame_tick, and all digits show 79 from the next frame.
REQ-034 SHALL cover leading-zero suppression: value=16'h0000, blank_lz=1 -> digits 3..1 blank (7F) and digit 0 shows 40; value=16'h0050 -> digits 3,2 blank, digits 1,0 show 12,40.
REQ-035 SHALL cover the load/boundary race: load 16'h2222 in the frame_tick cycle -> that frame shows 24 on all digits.
REQ-036 SHALL cover blink with SEG_SCAN_BLINK_EN defined: blink_mask=4'b0001 -> digit 0 is 7F during frames 2-3, visible during frames 0-1 and 4-5; without the macro, digit 0 is always visible.
